// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: pulls 1-3 instruction bytes from a synchronous ROM, presents them to execute, owns the PC.
// Each byte takes 4 cycles and the instruction is held until exec_done_i. A halt parks the unit until reset.
module instr_fetch_unit #(
   parameter int                    ADDR_WIDTH = 16,
   parameter int                    DATA_WIDTH = 8,
   parameter logic [ADDR_WIDTH-1:0] RESET_VEC  = 16'hF000
) (
   input  logic                  clk,
   input  logic                  reset,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic                  mem_rd_o,
   input  logic [DATA_WIDTH-1:0] mem_data_i,
   input  logic [1:0]            len_i,
   output logic [DATA_WIDTH-1:0] opcode_o,
   output logic [DATA_WIDTH-1:0] temp_1_out,
   output logic [DATA_WIDTH-1:0] temp_2_out,
   output logic                  instr_vld_o,
   input  logic                  exec_done_i,
   input  logic                  pc_load_i,
   input  logic [ADDR_WIDTH-1:0] pc_load_addr_i,
   input  logic                  halt_i,
   output logic [ADDR_WIDTH-1:0] counter_out,
   output logic                  halted_o
);

   typedef enum logic [2:0] {
      F_ADDR  = 3'd0,
      F_WAIT  = 3'd1,
      F_LATCH = 3'd2,
      F_INC   = 3'd3,
      ISSUE   = 3'd4,
      HALTED  = 3'd5
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] PC_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

   state_t     state;
   logic [1:0] byte_idx;
   logic [1:0] len_eff;

   // A zero length from the decoder still means the opcode byte itself.
   assign len_eff    = (len_i == 2'd0) ? 2'd1 : len_i;
   assign mem_addr_o = counter_out;
   // Reads are suppressed while reset is held so a reset cycle never touches memory.
   assign mem_rd_o   = (state == F_ADDR) && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= F_ADDR;
         byte_idx    <= 2'd0;
         counter_out <= RESET_VEC;
         opcode_o    <= '0;
         temp_1_out  <= '0;
         temp_2_out  <= '0;
         instr_vld_o <= 1'b0;
         halted_o    <= 1'b0;
      end else begin
         case (state)
            F_ADDR:  state <= F_WAIT;
            F_WAIT:  state <= F_LATCH;
            F_LATCH: begin
               case (byte_idx)
                  2'd0:    opcode_o   <= mem_data_i;
                  2'd1:    temp_1_out <= mem_data_i;
                  default: temp_2_out <= mem_data_i;
               endcase
               state <= F_INC;
            end
            F_INC: begin
               counter_out <= counter_out + PC_ONE;
               if ((byte_idx + 2'd1) < len_eff) begin
                  byte_idx <= byte_idx + 2'd1;
                  state    <= F_ADDR;
               end else begin
                  byte_idx    <= 2'd0;
                  instr_vld_o <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (exec_done_i) begin
                  instr_vld_o <= 1'b0;
                  if (halt_i) begin
                     halted_o <= 1'b1;
                     state    <= HALTED;
                  end else begin
                     if (pc_load_i)
                        counter_out <= pc_load_addr_i;
                     state <= F_ADDR;
                  end
               end
            end
            HALTED:  state <= HALTED;
            default: state <= F_ADDR;
         endcase
      end
   end

endmodule
